// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter
// Description : Two-port round-robin APB master front-end with wait-state
//               timeout; registered APB outputs and per-port completion status.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_write,
    output logic                  req0_ack,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_write,
    output logic                  req1_ack,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SETUP  = 2'd1;
    localparam logic [1:0] c_S_ACCESS = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic                  r_grant;
    logic                  r_last_grant;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_pwrite;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_err0;
    logic                  r_err1;

    logic                  w_grant;
    logic                  w_last_grant;
    logic [c_CNT_W-1:0]    w_cnt;
    logic [ADDR_WIDTH-1:0] w_paddr;
    logic [DATA_WIDTH-1:0] w_pwdata;
    logic                  w_pwrite;
    logic                  w_psel;
    logic                  w_penable;
    logic                  w_ack0;
    logic                  w_ack1;
    logic [DATA_WIDTH-1:0] w_rdata0;
    logic [DATA_WIDTH-1:0] w_rdata1;
    logic                  w_err0;
    logic                  w_err1;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_any_elig;
    logic                  w_pick;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_timeout_hit;
    logic                  w_done;
    logic                  w_done_err;
    logic                  w_done_upd;
    logic [DATA_WIDTH-1:0] w_done_rdata;

    // A port whose ack is showing this cycle is not eligible, so a requester
    // that drops valid on seeing ack is never granted a second time.
    assign w_elig0    = req0_valid & ~r_ack0;
    assign w_elig1    = req1_valid & ~r_ack1;
    assign w_any_elig = w_elig0 | w_elig1;
    assign w_pick     = (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;

    assign w_cnt_inc     = (r_cnt == c_TIMEOUT) ? r_cnt : (r_cnt + c_CNT_W'(1));
    assign w_timeout_hit = (TIMEOUT != 0) && (w_cnt_inc == c_TIMEOUT);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_any_elig) begin
                    w_state_nxt = c_S_SETUP;
                end
            end
            c_S_SETUP: begin
                w_state_nxt = c_S_ACCESS;
            end
            c_S_ACCESS: begin
                if (PREADY || w_timeout_hit) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_grant      = r_grant;
        w_last_grant = r_last_grant;
        w_cnt        = r_cnt;
        w_paddr      = r_paddr;
        w_pwdata     = r_pwdata;
        w_pwrite     = r_pwrite;
        w_psel       = r_psel;
        w_penable    = r_penable;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        w_rdata0     = r_rdata0;
        w_rdata1     = r_rdata1;
        w_err0       = r_err0;
        w_err1       = r_err1;
        w_done       = 1'b0;
        w_done_err   = 1'b0;
        w_done_upd   = 1'b0;
        w_done_rdata = '0;

        case (r_state)
            c_S_IDLE: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
                if (w_any_elig) begin
                    w_grant      = w_pick;
                    w_last_grant = w_pick;
                    w_psel       = 1'b1;
                    if (w_pick) begin
                        w_paddr  = req1_addr;
                        w_pwrite = req1_write;
                        w_pwdata = req1_write ? req1_wdata : '0;
                    end else begin
                        w_paddr  = req0_addr;
                        w_pwrite = req0_write;
                        w_pwdata = req0_write ? req0_wdata : '0;
                    end
                end
            end
            c_S_SETUP: begin
                w_penable = 1'b1;
                w_cnt     = '0;
            end
            c_S_ACCESS: begin
                if (PREADY) begin
                    // A ready slave wins over a timeout landing on the same edge.
                    w_done       = 1'b1;
                    w_done_err   = PSLVERR;
                    w_done_upd   = ~r_pwrite;
                    w_done_rdata = PRDATA;
                end else begin
                    w_cnt = w_cnt_inc;
                    if (w_timeout_hit) begin
                        w_done       = 1'b1;
                        w_done_err   = 1'b1;
                        w_done_upd   = ~r_pwrite;
                        w_done_rdata = '0;
                    end
                end
            end
            default: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
            end
        endcase

        if (w_done) begin
            w_psel    = 1'b0;
            w_penable = 1'b0;
            if (r_grant) begin
                w_ack1 = 1'b1;
                w_err1 = w_done_err;
                if (w_done_upd) begin
                    w_rdata1 = w_done_rdata;
                end
            end else begin
                w_ack0 = 1'b1;
                w_err0 = w_done_err;
                if (w_done_upd) begin
                    w_rdata0 = w_done_rdata;
                end
            end
        end
    end

    // last_grant resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_pwrite     <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_grant      <= w_grant;
            r_last_grant <= w_last_grant;
            r_cnt        <= w_cnt;
            r_paddr      <= w_paddr;
            r_pwdata     <= w_pwdata;
            r_pwrite     <= w_pwrite;
            r_psel       <= w_psel;
            r_penable    <= w_penable;
            r_ack0       <= w_ack0;
            r_ack1       <= w_ack1;
            r_rdata0     <= w_rdata0;
            r_rdata1     <= w_rdata1;
            r_err0       <= w_err0;
            r_err1       <= w_err1;
        end
    end

    assign PADDR      = r_paddr;
    assign PWDATA     = r_pwdata;
    assign PWRITE     = r_pwrite;
    assign PSEL       = r_psel;
    assign PENABLE    = r_penable;
    assign req0_ack   = r_ack0;
    assign req1_ack   = r_ack1;
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;
    assign req0_err   = r_err0;
    assign req1_err   = r_err1;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_arbiter
// Description : Randomized bench for apb_master_arbiter against a
//               transaction-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 4;
    localparam int NCYC = 3000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          valid [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          write [2];
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite, psel, penable;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;

    apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(clk), .PRESET(rst_n),
        .req0_valid(valid[0]), .req0_addr(addr[0]), .req0_wdata(wdata[0]), .req0_write(write[0]),
        .req0_ack(ack0), .req0_rdata(rdata0), .req0_err(err0),
        .req1_valid(valid[1]), .req1_addr(addr[1]), .req1_wdata(wdata[1]), .req1_write(write[1]),
        .req1_ack(ack1), .req1_rdata(rdata1), .req1_err(err1),
        .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    // Second instance with the timeout disabled, used for the hung-slave case.
    logic          nt_valid, nt_write, nt_pready, nt_pslverr;
    logic [AW-1:0] nt_addr;
    logic [DW-1:0] nt_wdata, nt_prdata;
    logic [AW-1:0] nt_paddr;
    logic [DW-1:0] nt_pwdata, nt_rdata0, nt_rdata1;
    logic          nt_pwrite, nt_psel, nt_penable, nt_ack0, nt_ack1, nt_err0, nt_err1;

    apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut_nt (
        .PCLK(clk), .PRESET(rst_n),
        .req0_valid(nt_valid), .req0_addr(nt_addr), .req0_wdata(nt_wdata), .req0_write(nt_write),
        .req0_ack(nt_ack0), .req0_rdata(nt_rdata0), .req0_err(nt_err0),
        .req1_valid(1'b0), .req1_addr('0), .req1_wdata('0), .req1_write(1'b0),
        .req1_ack(nt_ack1), .req1_rdata(nt_rdata1), .req1_err(nt_err1),
        .PADDR(nt_paddr), .PWDATA(nt_pwdata), .PWRITE(nt_pwrite), .PSEL(nt_psel), .PENABLE(nt_penable),
        .PRDATA(nt_prdata), .PREADY(nt_pready), .PSLVERR(nt_pslverr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: each grant fixes a schedule (setup cycle s, k access
    // cycles, ack in cycle s+k+1) from which every output is derived.
    bit            m_busy;
    int            m_port, m_s, m_k, m_w;
    bit            m_to;
    bit            m_last;
    logic [DW-1:0] m_prdata;
    bit            m_slverr;
    logic [AW-1:0] exp_paddr;
    logic [DW-1:0] exp_pwdata;
    logic          exp_pwrite;
    logic [DW-1:0] exp_rdata [2];
    logic          exp_err   [2];
    bit            exp_ack   [2];
    int            done_cnt  [2];
    int            n_resets;

    function automatic void model_reset();
        m_busy     = 1'b0;
        m_last     = 1'b1;
        exp_paddr  = '0;
        exp_pwdata = '0;
        exp_pwrite = 1'b0;
        for (int p = 0; p < 2; p++) begin
            exp_rdata[p] = '0;
            exp_err[p]   = 1'b0;
            exp_ack[p]   = 1'b0;
        end
    endfunction

    task automatic new_req(input int p);
        valid[p] = 1'b1;
        addr[p]  = $urandom & 32'hFFFF_FFFC;
        wdata[p] = $urandom;
        write[p] = 1'($urandom_range(0, 1));
    endtask

    task automatic compare_all();
        bit e_psel, e_pen;
        e_psel = m_busy && cyc >= m_s && cyc <= m_s + m_k;
        e_pen  = m_busy && cyc >= m_s + 1 && cyc <= m_s + m_k;
        check("psel", psel, e_psel);
        check("penable", penable, e_pen);
        check("paddr", paddr, exp_paddr);
        check("pwdata", pwdata, exp_pwdata);
        check("pwrite", pwrite, exp_pwrite);
        check("ack0", ack0, exp_ack[0]);
        check("ack1", ack1, exp_ack[1]);
        check("rdata0", rdata0, exp_rdata[0]);
        check("rdata1", rdata1, exp_rdata[1]);
        check("err0", err0, exp_err[0]);
        check("err1", err1, exp_err[1]);
    endtask

    initial begin
        int psel_cnt, ack_cnt, p;
        bit e0, e1;
        logic [DW-1:0] nt_exp;

        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; addr[i] = '0; wdata[i] = '0; write[i] = 1'b0;
            done_cnt[i] = 0;
        end
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        nt_valid = 1'b0; nt_write = 1'b0; nt_addr = '0; nt_wdata = '0;
        nt_pready = 1'b0; nt_prdata = '0; nt_pslverr = 1'b0;
        n_resets = 0;
        model_reset();

        for (int it = 0; it < NCYC; it++) begin
            @(negedge clk);
            cyc++;

            for (int q = 0; q < 2; q++) exp_ack[q] = 1'b0;
            if (m_busy && cyc == m_s + m_k + 1) begin
                exp_ack[m_port] = 1'b1;
                exp_err[m_port] = m_to ? 1'b1 : m_slverr;
                if (!exp_pwrite) exp_rdata[m_port] = m_to ? '0 : m_prdata;
                m_busy = 1'b0;
            end

            compare_all();

            if (!rst_n) begin
                rst_n = 1'b1;
            end else if (it > 50 && n_resets < 3 && m_busy && cyc >= m_s + 1 &&
                         cyc < m_s + m_k && $urandom_range(0, 7) == 0) begin
                #3 rst_n = 1'b0;
                #1;
                check("rst_async_psel", psel, 1'b0);
                check("rst_async_penable", penable, 1'b0);
                check("rst_async_paddr", paddr, '0);
                check("rst_async_ack", {ack1, ack0}, 2'b00);
                model_reset();
                n_resets++;
            end

            for (int q = 0; q < 2; q++) begin
                if (exp_ack[q]) begin
                    done_cnt[q]++;
                    if ($urandom_range(0, 2) != 0) new_req(q);
                    else valid[q] = 1'b0;
                end else if (!valid[q] && $urandom_range(0, 3) == 0) begin
                    new_req(q);
                end
            end

            if (rst_n && !m_busy) begin
                e0 = valid[0] && !exp_ack[0];
                e1 = valid[1] && !exp_ack[1];
                if (e0 || e1) begin
                    p = (e0 && e1) ? (m_last ? 0 : 1) : (e1 ? 1 : 0);
                    m_last     = (p == 1);
                    m_port     = p;
                    m_busy     = 1'b1;
                    m_s        = cyc + 1;
                    m_w        = $urandom_range(0, 6);
                    m_to       = (TO != 0) && (m_w >= TO);
                    m_k        = m_to ? TO : m_w + 1;
                    m_prdata   = $urandom;
                    m_slverr   = ($urandom_range(0, 3) == 0);
                    exp_paddr  = addr[p];
                    exp_pwrite = write[p];
                    exp_pwdata = write[p] ? wdata[p] : '0;
                end
            end

            if (m_busy && !m_to && cyc == m_s + 1 + m_w) begin
                pready = 1'b1; prdata = m_prdata; pslverr = m_slverr;
            end else if (m_busy && cyc >= m_s + 1) begin
                pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
            end else begin
                pready = 1'($urandom_range(0, 1)); prdata = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
        end

        check("port0_served", done_cnt[0] > 0, 1'b1);
        check("port1_served", done_cnt[1] > 0, 1'b1);
        check("reset_injected", n_resets > 0, 1'b1);

        valid[0] = 1'b0;
        valid[1] = 1'b0;
        @(negedge clk);
        nt_valid  = 1'b1;
        nt_write  = 1'b0;
        nt_addr   = 32'h0000_0024;
        nt_pready = 1'b0;
        psel_cnt  = 0;
        ack_cnt   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            psel_cnt += int'(nt_psel);
            ack_cnt  += int'(nt_ack0);
        end
        check("nt_psel_cycles", psel_cnt, 100);
        check("nt_no_ack_while_hung", ack_cnt, 0);
        check("nt_paddr", nt_paddr, 32'h0000_0024);
        nt_exp     = 32'hDEAD_BEEF;
        nt_prdata  = nt_exp;
        nt_pslverr = 1'b0;
        nt_pready  = 1'b1;
        @(negedge clk);
        nt_valid  = 1'b0;
        nt_pready = 1'b0;
        check("nt_ack", nt_ack0, 1'b1);
        check("nt_rdata", nt_rdata0, nt_exp);
        check("nt_err", nt_err0, 1'b0);
        @(negedge clk);
        check("nt_psel_after", nt_psel, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-port APB master front-end that shares a single APB bus between two local requesters (e.g. a CPU-side register port and a DMA/test engine). It arbitrates round-robin, sequences each granted request through the APB IDLE → SETUP → ACCESS protocol, handles slave wait states and PSLVERR, and returns read data, a completion strobe and an error flag to the requester that was served. A programmable wait-state timeout stops a hung slave from locking the bus.

## Interface
- addr_width, 32, width of PADDR and reqN_addr
- data_width, 32, width of PWDATA, PRDATA, reqN_wdata and reqN_rdata
- timeout, 16, maximum ACCESS cycles with PREADY low before forced error completion; 0 disables the timeout
- PCLK  in  1  bus clock; all state changes on the rising edge
- PRESET  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending; held high with stable payload until the matching ack
- req0_addr / req1_addr  in  addr_width  transfer address
- req0_wdata / req1_wdata  in  data_width  write data (ignored for reads)
- req0_write / req1_write  in  1  1 = write, 0 = read
- req0_ack / req1_ack  out  1  one-cycle completion pulse
- req0_rdata / req1_rdata  out  data_width  read data captured at completion; held until that port's next completion
- req0_err / req1_err  out  1  completion status (PSLVERR or timeout); held like rdata
- PADDR  out  addr_width; PWDATA  out  data_width; PWRITE  out  1; PSEL  out  1; PENABLE  out  1
- PRDATA  in  data_width; PREADY  in  1; PSLVERR  in  1

## Operation
- States: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE: eligible = reqN_valid & !reqN_ack. If neither port is eligible, stay in IDLE. If exactly one is eligible, grant it. If both are eligible, grant the port that is not last_grant. On a grant: latch grant and last_grant, load PADDR, PWRITE, and PWDATA (PWDATA = 0 for reads), set PSEL=1 and PENABLE=0, then go to SETUP.
- SETUP: set PENABLE=1, clear the wait counter, then go to ACCESS. It lasts exactly one cycle.
- ACCESS, PREADY=1: complete the transfer. Set PSEL=0, PENABLE=0, and pulse ack[grant]. If PWRITE=0, set rdata[grant]=PRDATA; for writes, rdata is unchanged. Set err[grant]=PSLVERR, then go to IDLE.
- ACCESS, PREADY=0: increment the wait counter, which saturates at timeout.
  - If timeout≠0 and the counter reaches timeout, complete with err[grant]=1. For reads, rdata[grant]=0. Go to IDLE.
  - Otherwise hold all APB outputs stable.
- PADDR, PWDATA and PWRITE hold their values in IDLE. Only PSEL and PENABLE return to 0.
- Wait counter width: clog2(timeout+1), minimum 1 bit.
- Requests are never pre-empted once granted.
- The reqN_valid inputs are sampled only in IDLE. A change during SETUP or ACCESS has no effect on the transfer in progress.

## Timing
- Reset (PRESET low, asynchronous, any state including mid-ACCESS): PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, all ack=0, all rdata=0, all err=0, state=IDLE, last_grant=1 (so req0 wins the first tie), wait counter=0. No ack is issued for an aborted transfer.
- Grant edge e (IDLE): PSEL rises after e. Edge e+1: PENABLE rises. The earliest completion is edge e+2 with PREADY=1.
- ack is high for exactly the cycle after the completing edge. rdata and err are valid in the same cycle as ack.
- The IDLE cycle that coincides with ack masks the acked port, so a requester that drops valid on seeing ack is never re-granted. The other port can be granted in that same cycle.
- Minimum transfer period is 3 cycles (SETUP, ACCESS, IDLE). Each wait state adds 1 cycle.
- With timeout=T, a transfer that never sees PREADY completes on the T-th ACCESS edge with PREADY low. Total PSEL high time is T+1 cycles.
- If PREADY=1 and the counter reaches timeout on the same edge, PREADY wins and err=PSLVERR.

## Test plan
- Reset then single write: req0 write addr 0x10, wdata 0xA5A5_0001, PREADY tied 1. Expect PSEL high 2 cycles, PENABLE high 1 cycle, PWRITE=1, PADDR=0x10, req0_ack one pulse, req0_err=0. Next IDLE has no re-grant.
- Read with 3 wait states: req1 read addr 0x24, PREADY low for 3 ACCESS cycles, PRDATA=0xDEAD_BEEF. Expect PENABLE high 4 cycles, APB outputs stable, req1_rdata=0xDEAD_BEEF with req1_ack.
- Contention: both valid from reset, 4 back-to-back transfers each. Expect grant order 0,1,0,1,… Each completion is followed by one IDLE cycle, and the next SETUP starts in that IDLE cycle's successor.
- PSLVERR: req0 read with PSLVERR=1 at completion. Expect req0_err=1 and req0_rdata=PRDATA. The following req0 transfer with PSLVERR=0 clears req0_err.
- Timeout: timeout=4, PREADY held 0. Expect forced completion on the 4th ACCESS edge, req_err=1, rdata=0 for a read, PSEL low afterwards. With timeout=0, PSEL stays high for 100 cycles.
- Reset mid-ACCESS: assert PRESET low during a wait state. Expect PSEL, PENABLE and PADDR to be 0 immediately without waiting for PCLK, and no ack. After release, the still-valid requester is re-granted and completes normally.
